// File: rtl/najla_stream_scoreboard.sv
// Stream scoreboard: buffers expected samples in a FIFO and compares them lane by lane
// against the actual stream. Optional watchdog is built when NAJLA_SB_TIMEOUT_EN is defined.
module najla_stream_scoreboard #(
  parameter int          W       = 64,
  parameter int          LANES   = 2,
  parameter int          DEPTH   = 16,
  parameter int unsigned NSAMP   = 1024,
  parameter int          MAXLOG  = 5,
  parameter int          TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  exp_valid,
  output logic                  exp_ready,
  input  logic [LANES*W-1:0]    exp_data,
  input  logic                  act_valid,
  output logic                  act_ready,
  input  logic [LANES*W-1:0]    act_data,
  output logic [LANES*32-1:0]   mism_cnt,
  output logic [31:0]           sample_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic                  log_valid,
  output logic [31:0]           log_index,
  output logic [LANES-1:0]      log_lanes
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] LAST_IDX = 32'(NSAMP - 1);
  localparam logic [31:0] LOG_MAX  = 32'(MAXLOG);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [LANES*W-1:0]   mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic [31:0]          log_cnt;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 wd_fire;
  logic [LANES-1:0]     lane_mism;
  logic [LANES-1:0]     lane_nz;

  assign full      = (count == (AW+1)'(DEPTH));
  assign exp_ready = (state == RUN) && !full;
  assign act_ready = (state == RUN) && (count != '0);
  assign push      = exp_valid && exp_ready;
  assign pop       = act_valid && act_ready;

  // Per-lane compare against the FIFO head; lane_nz tells whether a lane ends the sample with a nonzero count
  always_comb begin
    lane_mism = '0;
    lane_nz   = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_mism[k] = (act_data[k*W +: W] != mem[rd_ptr][k*W +: W]);
      lane_nz[k]   = lane_mism[k] || (mism_cnt[k*32 +: 32] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= exp_data;
  end

`ifdef NAJLA_SB_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        timeout_q;

  assign wd_fire = (state == RUN) && !pop && (idle_cnt == 32'(TIMEOUT - 1));
  assign timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (state != RUN) begin
      if (start) begin
        idle_cnt  <= '0;
        timeout_q <= 1'b0;
      end
    end else if (pop) begin
      idle_cnt <= '0;
    end else if (wd_fire) begin
      timeout_q <= 1'b1;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    log_valid <= 1'b0;
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      log_cnt    <= '0;
      sample_cnt <= '0;
      mism_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      log_index  <= '0;
      log_lanes  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            log_cnt    <= '0;
            sample_cnt <= '0;
            mism_cnt   <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
          end
        end
        RUN: begin
          if (push) wr_ptr <= wr_ptr + AW'(1);
          if (pop)  rd_ptr <= rd_ptr + AW'(1);
          count <= count + (AW+1)'(push) - (AW+1)'(pop);
          if (pop) begin
            sample_cnt <= sample_cnt + 32'd1;
            for (int k = 0; k < LANES; k++) begin
              if (lane_mism[k] && (mism_cnt[k*32 +: 32] != '1))
                mism_cnt[k*32 +: 32] <= mism_cnt[k*32 +: 32] + 32'd1;
            end
            if ((lane_mism != '0) && (log_cnt < LOG_MAX)) begin
              log_valid <= 1'b1;
              log_index <= sample_cnt;
              log_lanes <= lane_mism;
              log_cnt   <= log_cnt + 32'd1;
            end
            if (sample_cnt == LAST_IDX) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (lane_nz == '0);
            end
          end else if (wd_fire) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_najla_stream_scoreboard.sv
// Directed bench for najla_stream_scoreboard: table of run scenarios plus hand-written
// sequences for FIFO backpressure, mid-run reset and the watchdog.
module tb_najla_stream_scoreboard;

  localparam int W       = 16;
  localparam int LANES   = 2;
  localparam int DEPTH   = 4;
  localparam int NSAMP   = 8;
  localparam int MAXLOG  = 5;
  localparam int TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                exp_valid;
  logic                exp_ready;
  logic [LANES*W-1:0]  exp_data;
  logic                act_valid;
  logic                act_ready;
  logic [LANES*W-1:0]  act_data;
  logic [LANES*32-1:0] mism_cnt;
  logic [31:0]         sample_cnt;
  logic                busy;
  logic                done;
  logic                pass;
  logic                timeout;
  logic                log_valid;
  logic [31:0]         log_index;
  logic [LANES-1:0]    log_lanes;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  najla_stream_scoreboard #(
    .W(W), .LANES(LANES), .DEPTH(DEPTH), .NSAMP(NSAMP), .MAXLOG(MAXLOG), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .mism_cnt(mism_cnt), .sample_cnt(sample_cnt),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .log_valid(log_valid), .log_index(log_index), .log_lanes(log_lanes)
  );

  typedef struct {
    string       name;
    logic [7:0]  bad0;
    logic [7:0]  bad1;
    logic [31:0] m0;
    logic [31:0] m1;
    logic        ps;
    int          nlog;
    logic [31:0] first_idx;
    logic [31:0] last_idx;
    logic [1:0]  lanes;
  } scen_t;

  scen_t tbl[4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  function automatic logic [LANES*W-1:0] gen(input int i);
    logic [15:0] l0;
    logic [15:0] l1;
    l0 = 16'h1000 + 16'(i);
    l1 = 16'h2000 + 16'(i);
    return {l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_done"},      32'(done), 32'd0);
    chk({tag, "_pass"},      32'(pass), 32'd0);
    chk({tag, "_timeout"},   32'(timeout), 32'd0);
    chk({tag, "_log_valid"}, 32'(log_valid), 32'd0);
    chk({tag, "_mism0"},     mism_cnt[31:0], 32'd0);
    chk({tag, "_mism1"},     mism_cnt[63:32], 32'd0);
    chk({tag, "_sample"},    sample_cnt, 32'd0);
    chk({tag, "_log_index"}, log_index, 32'd0);
    chk({tag, "_log_lanes"}, 32'(log_lanes), 32'd0);
    chk({tag, "_exp_ready"}, 32'(exp_ready), 32'd0);
    chk({tag, "_act_ready"}, 32'(act_ready), 32'd0);
  endtask

  // Full NSAMP-sample run with continuous valids; lanes flagged in bad0/bad1 are corrupted on the act side
  task automatic run_stream(input logic [7:0] bad0, input logic [7:0] bad1,
                            output int nlog, output logic [31:0] fidx, output logic [31:0] lidx,
                            output logic [1:0] llanes, output bit finished);
    int ei = 0;
    int ai = 0;
    bit ef;
    bit af;
    nlog = 0; fidx = '0; lidx = '0; llanes = '0; finished = 1'b0;
    pulse_start();
    for (int cyc = 0; cyc < 100; cyc++) begin
      exp_valid = (ei < NSAMP);
      exp_data  = gen(ei);
      act_valid = (ai < NSAMP);
      act_data  = gen(ai) ^ {15'b0, bad1[ai[2:0]], 15'b0, bad0[ai[2:0]]};
      #4;
      if (log_valid) begin
        if (nlog == 0) fidx = log_index;
        lidx   = log_index;
        llanes = log_lanes;
        nlog++;
      end
      if (done) begin
        finished = 1'b1;
        break;
      end
      ef = exp_valid && exp_ready;
      af = act_valid && act_ready;
      tick();
      if (ef) ei++;
      if (af) ai++;
    end
    exp_valid = 1'b0;
    act_valid = 1'b0;
  endtask

  initial begin
    int          nlog;
    logic [31:0] fidx;
    logic [31:0] lidx;
    logic [1:0]  llanes;
    bit          finished;
    int          pushes;
    int          waited;
    bit          ef;

    tbl[0] = '{"clean",      8'h00, 8'h00, 32'd0, 32'd0, 1'b1, 0, 32'd0, 32'd0, 2'b00};
    tbl[1] = '{"lane1_2_5",  8'h00, 8'h24, 32'd0, 32'd2, 1'b0, 2, 32'd2, 32'd5, 2'b10};
    tbl[2] = '{"lane0_all",  8'hFF, 8'h00, 32'd8, 32'd0, 1'b0, 5, 32'd0, 32'd4, 2'b01};
    tbl[3] = '{"both_last",  8'h80, 8'h80, 32'd1, 32'd1, 1'b0, 1, 32'd7, 32'd7, 2'b11};

    rst = 1'b1; start = 1'b0;
    exp_valid = 1'b0; act_valid = 1'b0; exp_data = '0; act_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_zero("reset");

    for (int s = 0; s < 4; s++) begin
      run_stream(tbl[s].bad0, tbl[s].bad1, nlog, fidx, lidx, llanes, finished);
      chk({tbl[s].name, "_finished"}, 32'(finished), 32'd1);
      chk({tbl[s].name, "_done"},     32'(done), 32'd1);
      chk({tbl[s].name, "_busy"},     32'(busy), 32'd0);
      chk({tbl[s].name, "_pass"},     32'(pass), 32'(tbl[s].ps));
      chk({tbl[s].name, "_timeout"},  32'(timeout), 32'd0);
      chk({tbl[s].name, "_sample"},   sample_cnt, 32'd8);
      chk({tbl[s].name, "_mism0"},    mism_cnt[31:0], tbl[s].m0);
      chk({tbl[s].name, "_mism1"},    mism_cnt[63:32], tbl[s].m1);
      chk({tbl[s].name, "_nlog"},     32'(nlog), 32'(tbl[s].nlog));
      chk({tbl[s].name, "_first_idx"}, fidx, tbl[s].first_idx);
      chk({tbl[s].name, "_last_idx"},  lidx, tbl[s].last_idx);
      chk({tbl[s].name, "_log_lanes"}, 32'(llanes), 32'(tbl[s].lanes));
      tick();
      chk({tbl[s].name, "_done_hold"}, 32'(done), 32'd1);
    end

    // FIFO fill with the act side stalled, then a single drain
    pulse_start();
    pushes = 0;
    for (int c = 0; c < 8; c++) begin
      exp_valid = (pushes < 6);
      exp_data  = gen(pushes);
      #4;
      ef = exp_valid && exp_ready;
      tick();
      if (ef) pushes++;
    end
    chk("fill_pushes", 32'(pushes), 32'd4);
    chk("fill_exp_ready", 32'(exp_ready), 32'd0);
    chk("fill_act_ready", 32'(act_ready), 32'd1);
    act_valid = 1'b1;
    act_data  = gen(0);
    #4;
    chk("pop_cycle_exp_ready", 32'(exp_ready), 32'd0);
    tick();
    act_valid = 1'b0;
    exp_valid = 1'b0;
    chk("after_pop_exp_ready", 32'(exp_ready), 32'd1);
    chk("after_pop_sample", sample_cnt, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Mid-run reset after 3 compares, with an ignored start while running
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      exp_valid = 1'b1;
      exp_data  = gen(i);
      tick();
    end
    exp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      act_valid = 1'b1;
      act_data  = gen(i);
      tick();
    end
    act_valid = 1'b0;
    chk("midrun_sample", sample_cnt, 32'd3);
    chk("midrun_act_ready", 32'(act_ready), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_run_sample", sample_cnt, 32'd3);
    chk("start_in_run_busy", 32'(busy), 32'd1);
    exp_valid = 1'b1;
    exp_data  = gen(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_valid = 1'b0;
    check_zero("midrun_rst");
    run_stream(8'h00, 8'h00, nlog, fidx, lidx, llanes, finished);
    chk("rerun_done", 32'(done), 32'd1);
    chk("rerun_pass", 32'(pass), 32'd1);
    chk("rerun_sample", sample_cnt, 32'd8);
    chk("rerun_nlog", 32'(nlog), 32'd0);

    // Stalled run: watchdog if built, otherwise the run never ends
    pulse_start();
    waited = 0;
    for (int c = 0; c < 40; c++) begin
      #4;
      if (done) break;
      waited++;
      tick();
    end
`ifdef NAJLA_SB_TIMEOUT_EN
    chk("wd_cycles", 32'(waited), 32'(TIMEOUT));
    chk("wd_done", 32'(done), 32'd1);
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_pass", 32'(pass), 32'd0);
`else
    chk("nowd_cycles", 32'(waited), 32'd40);
    chk("nowd_done", 32'(done), 32'd0);
    chk("nowd_timeout", 32'(timeout), 32'd0);
    chk("nowd_busy", 32'(busy), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
